// File: rtl/lifo_pkg.sv
// Shared types and constants for the LIFO stack and its storage array.
package lifo_pkg;

    localparam int LIFO_DATA_W = 8;
    localparam int LIFO_DEPTH  = 16;

    typedef logic [1:0] region_t;

    localparam region_t REGION_EMPTY   = 2'd0;
    localparam region_t REGION_PARTIAL = 2'd1;
    localparam region_t REGION_FULL    = 2'd2;

    // Selects which register drives the data output.
    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_MEM   = 2'd1,
        SRC_BYP   = 2'd2
    } dout_src_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// DEPTH x DATA_W register array with synchronous write and synchronous read.
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int DATA_W = LIFO_DATA_W,
    parameter int DEPTH  = LIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: storage has no reset; the owner tracks validity through its count,
    // and leaving the array unreset lets it map onto plain flops or RAM.
    // A read and a write to the same address on one edge return the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with replace-top/bypass on simultaneous push+pop.
// Define LIFO_ERR_FLAG_EN to add sticky OVF/UDF flags and the CLR_ERR input.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int DATA_W   = LIFO_DATA_W,
    parameter int DEPTH    = LIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int CW       = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic [CW-1:0]     count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              almost_empty_o
`ifdef LIFO_ERR_FLAG_EN
    ,
    input  logic              clr_err_i,
    output logic              ovf_o,
    output logic              udf_o
`endif
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [CW-1:0]     count_q, count_d;
    dout_src_e         src_q, src_d;
    logic [DATA_W-1:0] byp_q;
    logic              dout_valid_q;
    region_t           region;

    logic              do_push, do_pop, do_repl, do_byp;
    logic              mem_we, mem_re;
    logic [AW-1:0]     mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [CW-1:0]     top_idx;

    always_comb begin
        if (count_q == '0) begin
            region = REGION_EMPTY;
        end else if (count_q == DEPTH_C) begin
            region = REGION_FULL;
        end else begin
            region = REGION_PARTIAL;
        end
    end

    assign empty_o        = (region == REGION_EMPTY);
    assign full_o         = (region == REGION_FULL);
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign count_o        = count_q;

    assign do_push = en_i &  push_i & ~pop_i  & ~full_o;
    assign do_pop  = en_i & ~push_i &  pop_i  & ~empty_o;
    assign do_repl = en_i &  push_i &  pop_i  & ~empty_o;
    assign do_byp  = en_i &  push_i &  pop_i  &  empty_o;

    // top_idx wraps when empty but is only consumed on non-empty operations.
    assign top_idx   = count_q - CW'(1);
    assign mem_we    = do_push | do_repl;
    assign mem_re    = do_pop | do_repl;
    assign mem_waddr = do_push ? count_q[AW-1:0] : top_idx[AW-1:0];
    assign mem_raddr = top_idx[AW-1:0];

    // NOTE: combinational next-state uses blocking '=' with a default first so
    // no latch is inferred; the registers below use non-blocking '<='.
    always_comb begin
        count_d = count_q;
        src_d   = src_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
        if (mem_re) begin
            src_d = SRC_MEM;
        end else if (do_byp) begin
            src_d = SRC_BYP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            src_q        <= SRC_RESET;
            byp_q        <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            src_q        <= src_d;
            dout_valid_q <= mem_re | do_byp;
            if (do_byp) begin
                byp_q <= din_i;
            end
        end
    end

    // The read register lives in the memory; reset forces the visible output
    // to zero by selecting the reset source instead.
    always_comb begin
        dout_o = '0;
        unique case (src_q)
            SRC_MEM: dout_o = mem_rdata;
            SRC_BYP: dout_o = byp_q;
            default: dout_o = '0;
        endcase
    end

    assign dout_valid_o = dout_valid_q;

`ifdef LIFO_ERR_FLAG_EN
    logic ovf_q, udf_q;
    logic ovf_set, udf_set;

    assign ovf_set = en_i &  push_i & ~pop_i & full_o;
    assign udf_set = en_i & ~push_i &  pop_i & empty_o;

    // A set event on the same edge as CLR_ERR keeps the flag high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~clr_err_i);
            udf_q <= udf_set | (udf_q & ~clr_err_i);
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`endif

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (din_i),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack with DATA_W=8, DEPTH=4.
// Error-flag checks are compiled in only when LIFO_ERR_FLAG_EN is defined.
module tb_lifo_stack;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [CW-1:0] count;
    logic          empty, full, almost_full, almost_empty;
`ifdef LIFO_ERR_FLAG_EN
    logic          clr_err;
    logic          ovf, udf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    lifo_stack #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .AF_LEVEL (DEPTH - 2),
        .AE_LEVEL (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (en),
        .push_i         (push),
        .pop_i          (pop),
        .din_i          (din),
        .dout_o         (dout),
        .dout_valid_o   (dout_valid),
        .count_o        (count),
        .empty_o        (empty),
        .full_o         (full),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty)
`ifdef LIFO_ERR_FLAG_EN
        ,
        .clr_err_i      (clr_err),
        .ovf_o          (ovf),
        .udf_o          (udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation for a single clock edge, then sample 1 time unit later.
    task automatic op(input logic p_push, input logic p_pop, input logic [DW-1:0] p_din);
        push = p_push;
        pop  = p_pop;
        din  = p_din;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic check_state(input string tag, input int exp_count,
                               input logic [DW-1:0] exp_dout, input logic exp_valid);
        check({tag, ".count"}, 32'(count), 32'(exp_count));
        check({tag, ".dout"},  32'(dout), 32'(exp_dout));
        check({tag, ".valid"}, 32'(dout_valid), 32'(exp_valid));
    endtask

`ifdef LIFO_ERR_FLAG_EN
    task automatic clear_errors();
        clr_err = 1'b1;
        op(1'b0, 1'b0, 8'h00);
        clr_err = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        din   = '0;
`ifdef LIFO_ERR_FLAG_EN
        clr_err = 1'b0;
`endif
        #12;
        check_state("reset", 0, 8'h00, 1'b0);
        check("reset.empty", 32'(empty), 32'd1);
        check("reset.full", 32'(full), 32'd0);
        check("reset.ae", 32'(almost_empty), 32'd1);
        check("reset.af", 32'(almost_full), 32'd0);
`ifdef LIFO_ERR_FLAG_EN
        check("reset.ovf", 32'(ovf), 32'd0);
        check("reset.udf", 32'(udf), 32'd0);
`endif
        rst_n = 1'b1;

        // Fill the stack and watch the threshold flags move.
        op(1'b1, 1'b0, 8'h11);
        check_state("push1", 1, 8'h00, 1'b0);
        check("push1.af", 32'(almost_full), 32'd0);
        check("push1.empty", 32'(empty), 32'd0);
        op(1'b1, 1'b0, 8'h22);
        check("push2.count", 32'(count), 32'd2);
        check("push2.af", 32'(almost_full), 32'd1);
        check("push2.ae", 32'(almost_empty), 32'd1);
        op(1'b1, 1'b0, 8'h33);
        check("push3.count", 32'(count), 32'd3);
        check("push3.ae", 32'(almost_empty), 32'd0);
        check("push3.full", 32'(full), 32'd0);
        op(1'b1, 1'b0, 8'h44);
        check("push4.count", 32'(count), 32'd4);
        check("push4.full", 32'(full), 32'd1);

        // Push while full is dropped.
        op(1'b1, 1'b0, 8'h55);
        check_state("ovf_push", 4, 8'h00, 1'b0);
`ifdef LIFO_ERR_FLAG_EN
        check("ovf_push.ovf", 32'(ovf), 32'd1);
        check("ovf_push.udf", 32'(udf), 32'd0);
        clear_errors();
        check("ovf_clr.ovf", 32'(ovf), 32'd0);
`endif

        // Drain in reverse order.
        op(1'b0, 1'b1, 8'h00);
        check_state("pop1", 3, 8'h44, 1'b1);
        check("pop1.full", 32'(full), 32'd0);
        op(1'b0, 1'b1, 8'h00);
        check_state("pop2", 2, 8'h33, 1'b1);
        op(1'b0, 1'b1, 8'h00);
        check_state("pop3", 1, 8'h22, 1'b1);
        op(1'b0, 1'b1, 8'h00);
        check_state("pop4", 0, 8'h11, 1'b1);
        check("pop4.empty", 32'(empty), 32'd1);
        op(1'b0, 1'b0, 8'h00);
        check_state("idle_hold", 0, 8'h11, 1'b0);

        // Pop while empty is dropped and the output holds.
        op(1'b0, 1'b1, 8'h00);
        check_state("udf_pop", 0, 8'h11, 1'b0);
`ifdef LIFO_ERR_FLAG_EN
        check("udf_pop.udf", 32'(udf), 32'd1);
        clear_errors();
        check("udf_clr.udf", 32'(udf), 32'd0);
`endif

        // Replace-top at COUNT=2.
        op(1'b1, 1'b0, 8'hA0);
        op(1'b1, 1'b0, 8'hB0);
        op(1'b1, 1'b1, 8'hC0);
        check_state("replace", 2, 8'hB0, 1'b1);
        op(1'b0, 1'b1, 8'h00);
        check_state("replace_pop1", 1, 8'hC0, 1'b1);
        op(1'b0, 1'b1, 8'h00);
        check_state("replace_pop2", 0, 8'hA0, 1'b1);

        // Bypass when empty.
        op(1'b1, 1'b1, 8'h7E);
        check_state("bypass", 0, 8'h7E, 1'b1);
`ifdef LIFO_ERR_FLAG_EN
        check("bypass.ovf", 32'(ovf), 32'd0);
        check("bypass.udf", 32'(udf), 32'd0);
`endif
        op(1'b0, 1'b0, 8'h00);
        check_state("bypass_hold", 0, 8'h7E, 1'b0);

        // Global enable low ignores requests.
        op(1'b1, 1'b0, 8'h01);
        op(1'b1, 1'b0, 8'h02);
        op(1'b1, 1'b0, 8'h03);
        check("fill3.count", 32'(count), 32'd3);
        en = 1'b0;
        op(1'b1, 1'b0, 8'h04);
        check("en0_push.count", 32'(count), 32'd3);
        op(1'b0, 1'b1, 8'h00);
        check_state("en0_pop", 3, 8'h7E, 1'b0);
        en = 1'b1;

        // Asynchronous reset mid-cycle, with a push pending.
        push = 1'b1;
        din  = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 0, 8'h00, 1'b0);
        check("async_rst.empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        push  = 1'b0;
        rst_n = 1'b1;
        check("post_rst.count", 32'(count), 32'd0);

        // The stack is usable again after reset release.
        op(1'b1, 1'b0, 8'h5A);
        op(1'b0, 1'b1, 8'h00);
        check_state("post_rst_pop", 0, 8'h5A, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised synchronous LIFO stack with separate input and output data paths, configurable width and depth, occupancy count, and almost-full/almost-empty thresholds. Push and pop in the same cycle perform a replace-top, or a bypass when the stack is empty. Optional sticky overflow/underflow error flags. Used as the buffering element wherever the design needs last-in-first-out storage.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries (≥2)
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT ≥ AF_LEVEL
- AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT ≤ AE_LEVEL
- CLK  in  1  clock; rising edge active
- RESET_N  in  1  asynchronous reset, active-low
- EN  in  1  global enable; when 0, no state changes
- PUSH  in  1  push request
- POP  in  1  pop request
- DIN  in  DATA_W  push data
- DOUT  out  DATA_W  popped data, held until the next pop
- DOUT_VALID  out  1  one-cycle pulse when DOUT is updated
- COUNT  out  CW = $clog2(DEPTH+1)  current occupancy
- EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY  out  1 each  status flags, decoded from COUNT
- CLR_ERR  in  1  clears OVF/UDF (present only with LIFO_ERR_FLAG_EN)
- OVF, UDF  out  1 each  sticky error flags (present only with LIFO_ERR_FLAG_EN)

## Operation
- Storage: DEPTH×DATA_W array. Top of stack is entry COUNT-1.
- An operation is accepted only in cycles with EN=1. With EN=0, all requests are ignored and the error flags are not set.
- Push only (PUSH=1, POP=0):
  - Not FULL: mem[COUNT] ← DIN, COUNT+1.
  - FULL: dropped; COUNT unchanged; sets OVF.
- Pop only (PUSH=0, POP=1):
  - Not EMPTY: DOUT ← mem[COUNT-1], COUNT-1, DOUT_VALID=1.
  - EMPTY: dropped; DOUT holds; DOUT_VALID=0; sets UDF.
- Push and pop together:
  - Not EMPTY (FULL included): replace-top. DOUT ← old mem[COUNT-1], then mem[COUNT-1] ← DIN. COUNT unchanged. DOUT_VALID=1. No error.
  - EMPTY: bypass. DOUT ← DIN, COUNT stays 0, DOUT_VALID=1. Memory is untouched. No error.
- Occupancy regions, derived from COUNT:
  - EMPTY (COUNT=0)
  - PARTIAL (0<COUNT<DEPTH)
  - FULL (COUNT=DEPTH)
- No other state machine; all transitions follow the rules above.
- COUNT arithmetic is unsigned CW bits and never wraps: it saturates at 0 and DEPTH by construction.
- Memory contents are not reset. Only COUNT, DOUT, DOUT_VALID, OVF and UDF are reset.

## Timing
- Reset (RESET_N=0, asynchronous, takes effect immediately):
  - COUNT=0, DOUT=0, DOUT_VALID=0, OVF=0, UDF=0.
  - Resulting flags: EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0.
- Reset release is synchronous to CLK. The first operation is accepted on the first rising edge with RESET_N=1.
- A reset asserted mid-operation discards the in-flight push or pop. The stack reads empty afterwards.
- Push latency: data is stored and COUNT updated at the accepting edge. Flags reflect the new COUNT from that edge.
- Pop latency: 1 cycle. DOUT and DOUT_VALID are registered at the accepting edge.
- A push followed by a pop on the next cycle returns the just-pushed word. There is no read-during-write hazard.
- Flags are combinational decodes of registered COUNT. There is no combinational path from inputs to outputs.

## Configuration
- LIFO_ERR_FLAG_EN defined:
  - OVF sets on push-only while FULL; UDF sets on pop-only while EMPTY.
  - Both flags stay high until CLR_ERR=1 at a clock edge.
  - If a set event and CLR_ERR coincide, set wins.
- LIFO_ERR_FLAG_EN undefined:
  - CLR_ERR, OVF and UDF ports are absent and the logic is removed.
  - Illegal requests are still dropped silently.

## Structure
- Package lifo_pkg holds:
  - function cnt_w(depth) = $clog2(depth+1)
  - default DATA_W and DEPTH constants
  - localparam for the occupancy region encoding (EMPTY/PARTIAL/FULL)
- Sub-module lifo_mem: DEPTH×DATA_W register array with synchronous write (we, waddr, wdata) and synchronous read (re, raddr, rdata). lifo_stack owns the pointer/count logic, the bypass mux, and the flags.

## Test plan
- Reset, then DATA_W=8, DEPTH=4: push 0x11, 0x22, 0x33, 0x44 → COUNT=4, FULL=1, ALMOST_FULL=1 from COUNT=2. Then pop ×4 → DOUT 0x44, 0x33, 0x22, 0x11, each with a DOUT_VALID pulse; EMPTY=1 at the end.
- FULL, push 0x55 only → COUNT stays 4, top stays 0x44, OVF=1. CLR_ERR pulse → OVF=0.
- EMPTY, pop only → DOUT unchanged, DOUT_VALID=0, UDF=1.
- COUNT=2 (0xA0, 0xB0), PUSH+POP with DIN=0xC0 → DOUT=0xB0, COUNT=2. Next pop → 0xC0.
- EMPTY, PUSH+POP with DIN=0x7E → DOUT=0x7E, DOUT_VALID=1, COUNT=0, no UDF/OVF.
- COUNT=3, RESET_N low mid-cycle → COUNT=0 and DOUT=0 immediately, before any clock edge. EN=0 with PUSH=1 → COUNT unchanged.
